// File: rtl/output_io_pkg.sv
// Shared constants and tx FSM state encoding for the output-window responder
// and its UART transmitter.
package output_io_pkg;

    localparam logic [31:0] OUTPUT_BYTES_AVAI_ADDR = 32'h8000_0000;
    localparam logic [31:0] OUTPUT_BYTES_ADDR      = 32'h8000_0004;
    localparam logic [31:0] OUTPUT_OVF_CNT_ADDR    = 32'h8000_0008;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_8n1.sv
// 8N1 serial transmitter; idle also covers the last STOP cycle so a new byte
// can be loaded on the edge that leaves STOP, giving gapless back-to-back frames.
module uart_tx_8n1
    import output_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load,
    input  logic [7:0] data,
    output logic       txd,
    output logic       idle
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_e     r_state;
    tx_state_e     w_next;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          w_done;

    assign w_done = (r_baud == BAUD_LAST);

    always_comb begin
        w_next = r_state;
        idle   = 1'b0;
        txd    = 1'b1;
        case (r_state)
            IDLE: begin
                idle = 1'b1;
                if (load) w_next = START;
            end
            START: begin
                txd = 1'b0;
                if (w_done) w_next = DATA;
            end
            DATA: begin
                txd = r_shift[0];
                if (w_done && r_bit == 3'd7) w_next = STOP;
            end
            STOP: begin
                if (w_done) begin
                    idle   = 1'b1;
                    w_next = load ? START : IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_next;
            // Baud counter restarts on each bit boundary and every state change.
            if (w_next != r_state || r_state == IDLE || w_done)
                r_baud <= '0;
            else
                r_baud <= r_baud + 1'b1;
            if (load && idle) begin
                r_shift <= data;
                r_bit   <= '0;
            end else if (r_state == DATA && w_done) begin
                r_shift <= {1'b0, r_shift[7:1]};
                r_bit   <= r_bit + 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_byte_drain.sv
// Output-window responder: byte FIFO fed by core writes, drained through an 8N1 UART.
// Optional dropped-byte counter at 32'h8000_0008 enabled by OUTPUT_DRAIN_OVERFLOW_CNT_EN.
module output_byte_drain
    import output_io_pkg::*;
#(
    parameter int FIFO_DEPTH   = 16,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic [3:0]  we,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        rd_hit,
    output logic        uart_txd,
    output logic        tx_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_active;
    logic          w_wr;
    logic          w_rd;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_tx_idle;
    logic [CW-1:0] w_free;
    logic          w_unused;

    assign w_wr     = en && (we != 4'd0);
    assign w_rd     = en && (we == 4'd0);
    assign w_full   = (r_count == DEPTH_C);
    assign w_push   = w_wr && (addr == OUTPUT_BYTES_ADDR) && !w_full;
    assign w_pop    = w_tx_idle && (r_count != '0);
    assign w_free   = DEPTH_C - r_count;
    assign tx_busy  = r_active || (r_count != '0);
    assign w_unused = ^din[31:8];

    uart_tx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx (
        .clk    (clk),
        .reset_n(reset_n),
        .load   (w_pop),
        .data   (r_mem[r_rd_ptr]),
        .txd    (uart_txd),
        .idle   (w_tx_idle)
    );

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din[7:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_active <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
            // Frame-in-progress flag; the tx idle strobe alone would drop busy a cycle early.
            if (w_pop)          r_active <= 1'b1;
            else if (w_tx_idle) r_active <= 1'b0;
        end
    end

`ifdef OUTPUT_DRAIN_OVERFLOW_CNT_EN
    logic [31:0] r_ovf_cnt;
    logic        w_drop;

    assign w_drop = w_wr && (addr == OUTPUT_BYTES_ADDR) && w_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_ovf_cnt <= '0;
        else if (w_wr && addr == OUTPUT_OVF_CNT_ADDR)
            r_ovf_cnt <= '0;
        else if (w_drop && r_ovf_cnt != '1)
            r_ovf_cnt <= r_ovf_cnt + 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout   <= '0;
            rd_hit <= 1'b0;
        end else begin
            rd_hit <= 1'b0;
            if (w_rd) begin
                if (addr == OUTPUT_BYTES_AVAI_ADDR) begin
                    dout   <= 32'(w_free);
                    rd_hit <= 1'b1;
                end else if (addr == OUTPUT_BYTES_ADDR) begin
                    dout   <= '0;
                    rd_hit <= 1'b1;
                end
`ifdef OUTPUT_DRAIN_OVERFLOW_CNT_EN
                else if (addr == OUTPUT_OVF_CNT_ADDR) begin
                    dout   <= r_ovf_cnt;
                    rd_hit <= 1'b1;
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_output_byte_drain.sv
// Directed self-checking bench for output_byte_drain (FIFO_DEPTH=4, CLKS_PER_BIT=4).
module tb_output_byte_drain;

    localparam logic [31:0] A_AVAI = 32'h8000_0000;
    localparam logic [31:0] A_BYTE = 32'h8000_0004;
    localparam logic [31:0] A_OVF  = 32'h8000_0008;

    logic        clk;
    logic        reset_n;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic        rd_hit;
    logic        uart_txd;
    logic        tx_busy;

    int checks = 0;
    int errors = 0;

    output_byte_drain #(
        .FIFO_DEPTH  (4),
        .CLKS_PER_BIT(4)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (en),
        .we      (we),
        .addr    (addr),
        .din     (din),
        .dout    (dout),
        .rd_hit  (rd_hit),
        .uart_txd(uart_txd),
        .tx_busy (tx_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus drivers: each returns 1 time unit after the edge that sampled the access.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        en = 1'b1; we = 4'hF; addr = a; din = d;
        @(posedge clk); #1;
        en = 1'b0; we = 4'h0;
    endtask

    task automatic do_read(input logic [31:0] a);
        en = 1'b1; we = 4'h0; addr = a;
        @(posedge clk); #1;
        en = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; en = 1'b0; we = 4'h0; addr = '0; din = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dout !== 32'd0)   begin errors++; $display("FAIL reset_dout got=%0h exp=0", dout); end
        checks++; if (rd_hit !== 1'b0)  begin errors++; $display("FAIL reset_rd_hit got=%b exp=0", rd_hit); end
        checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL reset_txd got=%b exp=1", uart_txd); end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", tx_busy); end
        reset_n = 1'b1;
        @(posedge clk); #1;
        do_read(A_AVAI);
        checks++; if (rd_hit !== 1'b1) begin errors++; $display("FAIL reset_free_hit got=%b exp=1", rd_hit); end
        checks++; if (dout !== 32'd4)  begin errors++; $display("FAIL reset_free got=%0d exp=4", dout); end
    endtask

    task automatic test_single_frame();
        logic [7:0] b;
        logic       exp;
        int         bi;
        b = 8'h55;
        do_write(A_BYTE, 32'hFFFF_FF55);
        checks++; if (tx_busy !== 1'b1) begin errors++; $display("FAIL single_busy_after_push got=%b exp=1", tx_busy); end
        @(posedge clk); #1;
        for (int s = 0; s < 40; s++) begin
            bi  = s / 4;
            exp = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
            checks++;
            if (uart_txd !== exp) begin
                errors++; $display("FAIL single_frame_bit s=%0d got=%b exp=%b", s, uart_txd, exp);
            end
            @(posedge clk); #1;
        end
        checks++; if (tx_busy !== 1'b0)  begin errors++; $display("FAIL single_busy_end got=%b exp=0", tx_busy); end
        checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL single_txd_end got=%b exp=1", uart_txd); end
    endtask

    task automatic test_burst_overflow();
        logic [39:0] bs;
        logic [7:0]  b;
        logic        exp;
        int          fi;
        int          bi;
        bs = 40'h05_04_03_02_01;
        for (int i = 1; i <= 6; i++) do_write(A_BYTE, 32'(i));
        do_read(A_AVAI);
        checks++; if (rd_hit !== 1'b1) begin errors++; $display("FAIL burst_free_hit got=%b exp=1", rd_hit); end
        checks++; if (dout !== 32'd0)  begin errors++; $display("FAIL burst_free got=%0d exp=0", dout); end
        // Now 5 samples into the first frame; continue through all five frames.
        for (int s = 5; s < 200; s++) begin
            fi  = s / 40;
            bi  = (s % 40) / 4;
            b   = bs[8*fi +: 8];
            exp = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : b[bi-1];
            checks++;
            if (uart_txd !== exp) begin
                errors++; $display("FAIL burst_stream s=%0d got=%b exp=%b", s, uart_txd, exp);
            end
            @(posedge clk); #1;
        end
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL burst_busy_end got=%b exp=0", tx_busy); end
`ifdef OUTPUT_DRAIN_OVERFLOW_CNT_EN
        do_read(A_OVF);
        checks++; if (rd_hit !== 1'b1) begin errors++; $display("FAIL ovf_hit got=%b exp=1", rd_hit); end
        checks++; if (dout !== 32'd1)  begin errors++; $display("FAIL ovf_count got=%0d exp=1", dout); end
        do_write(A_OVF, 32'h0);
        do_read(A_OVF);
        checks++; if (dout !== 32'd0)  begin errors++; $display("FAIL ovf_clear got=%0d exp=0", dout); end
`else
        do_read(A_AVAI);
        do_read(A_OVF);
        checks++; if (rd_hit !== 1'b0) begin errors++; $display("FAIL ovf_absent_hit got=%b exp=0", rd_hit); end
        checks++; if (dout !== 32'd4)  begin errors++; $display("FAIL ovf_absent_dout got=%0d exp=4", dout); end
`endif
    endtask

    task automatic test_reset_mid_frame();
        do_write(A_BYTE, 32'h0);
        do_write(A_BYTE, 32'h0);
        repeat (9) begin @(posedge clk); #1; end
        checks++; if (uart_txd !== 1'b0) begin errors++; $display("FAIL midrst_pre_txd got=%b exp=0", uart_txd); end
        reset_n = 1'b0;
        #1;
        checks++; if (uart_txd !== 1'b1) begin errors++; $display("FAIL midrst_txd got=%b exp=1", uart_txd); end
        checks++; if (tx_busy !== 1'b0)  begin errors++; $display("FAIL midrst_busy got=%b exp=0", tx_busy); end
        @(posedge clk); #1;
        reset_n = 1'b1;
        do_read(A_AVAI);
        checks++; if (dout !== 32'd4) begin errors++; $display("FAIL midrst_free got=%0d exp=4", dout); end
        for (int c = 0; c < 50; c++) begin
            checks++;
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0) begin
                errors++; $display("FAIL midrst_quiet c=%0d txd=%b busy=%b exp txd=1 busy=0", c, uart_txd, tx_busy);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_misc_decode();
        do_write(A_AVAI, 32'h77);
        checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL misc_avai_write_busy got=%b exp=0", tx_busy); end
        checks++; if (rd_hit !== 1'b0)  begin errors++; $display("FAIL misc_write_hit got=%b exp=0", rd_hit); end
        do_read(32'h0000_1000);
        checks++; if (rd_hit !== 1'b0) begin errors++; $display("FAIL misc_other_hit got=%b exp=0", rd_hit); end
        checks++; if (dout !== 32'd4)  begin errors++; $display("FAIL misc_other_hold got=%0d exp=4", dout); end
        do_read(A_BYTE);
        checks++; if (rd_hit !== 1'b1) begin errors++; $display("FAIL misc_byte_hit got=%b exp=1", rd_hit); end
        checks++; if (dout !== 32'd0)  begin errors++; $display("FAIL misc_byte_dout got=%0d exp=0", dout); end
        addr = A_AVAI; en = 1'b0;
        @(posedge clk); #1;
        checks++; if (rd_hit !== 1'b0) begin errors++; $display("FAIL misc_en_low_hit got=%b exp=0", rd_hit); end
        do_read(A_AVAI);
        checks++; if (dout !== 32'd4)  begin errors++; $display("FAIL misc_free_after got=%0d exp=4", dout); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_burst_overflow();
        test_reset_mid_frame();
        test_misc_decode();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/output_byte_drain.md
# output_byte_drain

Memory-mapped output responder behind the unified memory's general-use port: it decodes core accesses to the output window at 32'h8000_0000, buffers each byte written to 32'h8000_0004 in a FIFO, and serialises buffered bytes out of an 8N1 UART transmitter. It also supplies the read data for the free-space register at 32'h8000_0000.

## Interface
- FIFO_DEPTH, 16: output buffer depth in bytes; power of two, ≥2.
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200); ≥2.
- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  access enable; same signal the memory port receives.
- we  in  4  byte write enables; any nonzero value is a write.
- addr  in  32  byte address.
- din  in  32  write data; only din[7:0] is used.
- dout  out  32  registered read data for output-window reads.
- rd_hit  out  1  registered; high in the cycle after an accepted window read, so the core selects dout over memory data.
- uart_txd  out  1  serial output, idle high.
- tx_busy  out  1  high when a frame is in progress or the FIFO is non-empty.

## Operation
- Write to 32'h8000_0004 (en=1, we≠0):
  - pushes din[7:0] when count < FIFO_DEPTH;
  - when full, the byte is dropped silently.
- Write to 32'h8000_0000: no effect.
- Read of 32'h8000_0000 (en=1, we=0): dout ← {zero-extend, FIFO_DEPTH − count} and rd_hit ← 1.
- Read of 32'h8000_0004: rd_hit ← 1 and dout ← 0.
- Any other address: rd_hit ← 0; dout holds its value.
- count width is $clog2(FIFO_DEPTH)+1. Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- Push and pop in the same cycle:
  - both take effect and count is unchanged;
  - the full check uses the pre-edge count, so a push while full is dropped even if a pop occurs in the same cycle.
- Pop: when the transmitter is IDLE and count > 0, the head byte is popped and loaded into the transmitter on the same edge.
- Transmitter FSM:
  - IDLE: txd=1. On load → START.
  - START: txd=0 for CLKS_PER_BIT cycles → DATA.
  - DATA: txd=shift[0] for CLKS_PER_BIT cycles per bit, LSB first. After 8 bits → STOP.
  - STOP: txd=1 for CLKS_PER_BIT cycles → IDLE.
- The bit counter is 3 bits. The baud counter counts 0..CLKS_PER_BIT−1 and clears on every state change.

## Timing
- Reset values:
  - dout=0, rd_hit=0, uart_txd=1, tx_busy=0;
  - FIFO empty (count=0, pointers 0); FSM in IDLE.
  - If the overflow counter is compiled in (see Configuration), it resets to 0.
- Reset asserted mid-frame: uart_txd goes to 1 immediately (asynchronous), the FIFO is flushed, and the partial frame is abandoned.
- Read latency is one edge: dout and rd_hit are valid after the edge that samples the read, matching the memory's dout timing.
- The free-space value reflects count before any push or pop on that same edge.
- Push at edge N into an empty FIFO with the FSM in IDLE: pop at edge N+1 and start bit from N+1. uart_txd falls in the cycle after N+1.
- Frame length is exactly 10·CLKS_PER_BIT cycles. Back-to-back frames have zero idle gap beyond the STOP bit: pop occurs on the edge that leaves STOP.
- tx_busy deasserts in the cycle after STOP ends when the FIFO is empty.

## Configuration
- OUTPUT_DRAIN_OVERFLOW_CNT_EN defined:
  - a 32-bit saturating counter of dropped bytes is added;
  - reads of 32'h8000_0008 return it (rd_hit=1);
  - any write to 32'h8000_0008 clears it;
  - an increment on the same edge as a clear: the clear wins.
- Undefined: no counter. 32'h8000_0008 is an ordinary address (rd_hit=0), and overflow drops are unobservable.

## Structure
- Shared package output_io_pkg holds:
  - OUTPUT_BYTES_AVAI_ADDR = 32'h8000_0000;
  - OUTPUT_BYTES_ADDR = 32'h8000_0004;
  - OUTPUT_OVF_CNT_ADDR = 32'h8000_0008;
  - the tx FSM state enum (IDLE, START, DATA, STOP).
- One sub-module, uart_tx_8n1:
  - ports: clk, reset_n, load, data[7:0], txd, idle;
  - parameter: CLKS_PER_BIT.
- FIFO storage, pointers, address decode and the counter stay in the top module.

## Test plan
Bench uses FIFO_DEPTH=4, CLKS_PER_BIT=4.
- Reset then read 32'h8000_0000 → next cycle rd_hit=1, dout=4; uart_txd=1, tx_busy=0.
- Write din=32'hFFFF_FF55 to 32'h8000_0004 → uart_txd serialises 0,1,0,1,0,1,0,1,0,1 with each bit held 4 cycles (40-cycle frame); tx_busy then drops.
- Write 6 bytes 8'h01..8'h06 on consecutive cycles → 8'h01 pops immediately and 8'h02–8'h05 are buffered, so 8'h06 is dropped. Free space reads 0 right after the burst. Output sequence is 01,02,03,04,05 with no inter-frame gap.
- Same burst with OUTPUT_DRAIN_OVERFLOW_CNT_EN → 32'h8000_0008 reads 1. A write to 32'h8000_0008 followed by a read → 0.
- Assert reset_n=0 at cycle 10 of a frame → uart_txd=1 immediately. After release, free space reads 4 and no further frames are sent.
- Write to 32'h8000_0000 and read 32'h1000 → no push occurs, and the read returns rd_hit=0 with dout unchanged.
